cfg_frame_loader: RTL and testbench

Configuration frame loader for the embedded FPGA fabric. It accepts a byte stream through a valid/ready handshake, locks onto a sync word, and decodes frame-write commands. It assembles each frame into a wide frame-data register and issues a one-cycle frame strobe with a column and frame address. That strobe drives the enable of the transparent configuration latches, which in turn feed the select inputs of the fabric's routing multiplexers. It sits between the bitstream transport (UART, SPI or external host) and the per-column frame-select decoding.

---
 rtl/cfg_frame_loader_if.sv | 31 +++
 rtl/cfg_frame_loader.sv | 215 +++++++++++++++++++++
 tb/tb_cfg_frame_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_frame_loader_if.sv
// rtl/cfg_frame_loader_if.sv - byte stream in, frame write port out, for the configuration frame loader
interface cfg_frame_loader_if #(
    parameter int FRAME_WORDS = 16,
    parameter int MAX_FRAMES  = 20,
    parameter int COLUMNS     = 16
);
    localparam int COL_W = $clog2(COLUMNS);
    localparam int IDX_W = $clog2(MAX_FRAMES);

    logic [7:0]                  s_data;
    logic                        s_valid;
    logic                        s_ready;
    logic [32*FRAME_WORDS-1:0]   frame_data;
    logic [COL_W-1:0]            frame_col;
    logic [IDX_W-1:0]            frame_idx;
    logic                        frame_strobe;
    logic                        synced;
    logic                        error;

    // Bitstream source side: drives bytes, observes the frame port and status
    modport master (
        output s_data, s_valid,
        input  s_ready, frame_data, frame_col, frame_idx, frame_strobe, synced, error
    );

    // Loader side
    modport slave (
        input  s_data, s_valid,
        output s_ready, frame_data, frame_col, frame_idx, frame_strobe, synced, error
    );
endinterface

// File: rtl/cfg_frame_loader.sv
// rtl/cfg_frame_loader.sv - sync-locked frame loader with strobe/hold sequencing; optional checksum byte via CFG_LOADER_CSUM_EN
module cfg_frame_loader #(
    parameter int FRAME_WORDS = 16,
    parameter int MAX_FRAMES  = 20,
    parameter int COLUMNS     = 16
) (
    input  logic               CLK,
    input  logic               resetn,
    cfg_frame_loader_if.slave  bus
);
    localparam int          COL_W = $clog2(COLUMNS);
    localparam int          IDX_W = $clog2(MAX_FRAMES);
    localparam int          WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int          DW    = 32 * FRAME_WORDS;
    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    typedef enum logic [2:0] {
        S_HUNT,
        S_HEADER,
        S_DATA,
        S_CSUM,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t             state_q;
    logic [31:0]        shift_q;
    logic [1:0]         byte_cnt_q;
    logic [WC_W-1:0]    word_cnt_q;
    logic [7:0]         remain_q;
    logic [COL_W-1:0]   pend_col_q;
    logic [IDX_W-1:0]   pend_idx_q;
    logic [DW-1:0]      frame_data_q;
    logic [COL_W-1:0]   frame_col_q;
    logic [IDX_W-1:0]   frame_idx_q;
    logic               strobe_q;
    logic               s_ready_q;
    logic               synced_q;
    logic               error_q;
`ifdef CFG_LOADER_CSUM_EN
    logic [7:0]         csum_q;
`endif

    logic               accept;
    logic [31:0]        word_d;
    logic               word_done;
    logic [7:0]         h_cmd;
    logic [7:0]         h_col;
    logic [7:0]         h_first;
    logic [7:0]         h_count;
    logic               h_col_ok;
    logic               h_range_ok;

    // Byte assembly and header field decode of the word completed by the current byte
    always_comb begin
        accept     = bus.s_valid & s_ready_q;
        word_d     = {shift_q[23:0], bus.s_data};
        word_done  = accept && (byte_cnt_q == 2'd3);
        h_cmd      = word_d[31:24];
        h_col      = word_d[23:16];
        h_first    = word_d[15:8];
        h_count    = word_d[7:0];
        h_col_ok   = ({1'b0, h_col} < 9'(COLUMNS));
        h_range_ok = (({1'b0, h_first} + {1'b0, h_count}) <= 9'(MAX_FRAMES));
    end

    // Loader sequencer: hunt, header decode, data shift, strobe and hold
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q      <= S_HUNT;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            remain_q     <= '0;
            pend_col_q   <= '0;
            pend_idx_q   <= '0;
            frame_data_q <= '0;
            frame_col_q  <= '0;
            frame_idx_q  <= '0;
            strobe_q     <= 1'b0;
            s_ready_q    <= 1'b0;
            synced_q     <= 1'b0;
            error_q      <= 1'b0;
`ifdef CFG_LOADER_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_HUNT: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        shift_q <= word_d;
                        // Unaligned search: any 4 consecutive bytes may form the sync word
                        if (word_d == SYNC_WORD) begin
                            synced_q   <= 1'b1;
                            error_q    <= 1'b0;
                            byte_cnt_q <= '0;
                            state_q    <= S_HEADER;
                        end
                    end
                end

                S_HEADER: begin
                    if (accept) begin
                        shift_q    <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                    if (word_done) begin
                        if (h_cmd == 8'h00) begin
                            synced_q <= 1'b0;
                            shift_q  <= '0;
                            state_q  <= S_HUNT;
                        end else if (h_cmd == 8'h01 && h_count == 8'd0) begin
                            state_q <= S_HEADER;
                        end else if (h_cmd == 8'h01 && h_col_ok && h_range_ok) begin
                            // Address is parked here and only reaches the outputs with the first data byte
                            pend_col_q <= h_col[COL_W-1:0];
                            pend_idx_q <= h_first[IDX_W-1:0];
                            remain_q   <= h_count;
                            word_cnt_q <= '0;
`ifdef CFG_LOADER_CSUM_EN
                            csum_q     <= '0;
`endif
                            state_q    <= S_DATA;
                        end else begin
                            error_q  <= 1'b1;
                            synced_q <= 1'b0;
                            shift_q  <= '0;
                            state_q  <= S_HUNT;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        shift_q     <= word_d;
                        byte_cnt_q  <= byte_cnt_q + 2'd1;
                        frame_col_q <= pend_col_q;
                        frame_idx_q <= pend_idx_q;
`ifdef CFG_LOADER_CSUM_EN
                        csum_q      <= csum_q ^ bus.s_data;
`endif
                    end
                    if (word_done) begin
                        frame_data_q <= {frame_data_q[DW-33:0], word_d};
                        word_cnt_q   <= word_cnt_q + 1'b1;
                        if (word_cnt_q == WC_W'(FRAME_WORDS - 1)) begin
                            word_cnt_q <= '0;
`ifdef CFG_LOADER_CSUM_EN
                            state_q    <= S_CSUM;
`else
                            s_ready_q  <= 1'b0;
                            strobe_q   <= 1'b1;
                            state_q    <= S_STROBE;
`endif
                        end
                    end
                end

                S_CSUM: begin
`ifdef CFG_LOADER_CSUM_EN
                    if (accept) begin
                        if (bus.s_data == csum_q) begin
                            s_ready_q <= 1'b0;
                            strobe_q  <= 1'b1;
                            state_q   <= S_STROBE;
                        end else begin
                            // Rejected frame stays visible in frame_data but is never strobed
                            error_q  <= 1'b1;
                            synced_q <= 1'b0;
                            shift_q  <= '0;
                            state_q  <= S_HUNT;
                        end
                    end
`else
                    state_q <= S_HUNT;
`endif
                end

                S_STROBE: begin
                    strobe_q <= 1'b0;
                    state_q  <= S_HOLD;
                end

                S_HOLD: begin
                    // Data and address held one more cycle for latch hold time, then advance
                    s_ready_q   <= 1'b1;
                    pend_idx_q  <= pend_idx_q + 1'b1;
                    frame_idx_q <= pend_idx_q + 1'b1;
                    remain_q    <= remain_q - 8'd1;
`ifdef CFG_LOADER_CSUM_EN
                    csum_q      <= '0;
`endif
                    if (remain_q == 8'd1) begin
                        state_q <= S_HEADER;
                    end else begin
                        state_q <= S_DATA;
                    end
                end

                default: begin
                    state_q <= S_HUNT;
                end
            endcase
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.frame_data   = frame_data_q;
    assign bus.frame_col    = frame_col_q;
    assign bus.frame_idx    = frame_idx_q;
    assign bus.frame_strobe = strobe_q;
    assign bus.synced       = synced_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb/tb_cfg_frame_loader.sv - scoreboard bench for cfg_frame_loader
module tb_cfg_frame_loader;
    localparam int FW = 16;
    localparam int MF = 20;
    localparam int NC = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    cfg_frame_loader_if #(.FRAME_WORDS(FW), .MAX_FRAMES(MF), .COLUMNS(NC)) bus ();

    cfg_frame_loader #(.FRAME_WORDS(FW), .MAX_FRAMES(MF), .COLUMNS(NC)) dut (
        .CLK    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      col;
        logic [4:0]      idx;
        logic [32*FW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 3; i >= 0; i--) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_byte(w[i*8 +: 8]);
        end
    endtask

`ifdef CFG_LOADER_CSUM_EN
    bit corrupt_csum = 1'b0;
`endif

    // Sends one frame of words base+k; pushes the expected strobe when push is set
    task automatic send_frame(input logic [31:0] base, input int gap_max, input bit push,
                              input logic [3:0] col, input logic [4:0] idx);
        exp_t e;
        logic [7:0] cs = 8'h00;
        e.col  = col;
        e.idx  = idx;
        e.data = '0;
        for (int k = 0; k < FW; k++) e.data = {e.data[32*FW-33:0], base + 32'(k)};
        if (push) sb.push_back(e);
        for (int k = 0; k < FW; k++) begin
            logic [31:0] w;
            w = base + 32'(k);
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send_word(w, gap_max);
        end
`ifdef CFG_LOADER_CSUM_EN
        send_byte(corrupt_csum ? (cs ^ 8'h01) : cs);
`else
        if (cs === 8'hxx) $display("note: checksum undefined");
`endif
    endtask

    task automatic do_sync();
        send_word(32'hFAB0_FAB1, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, 64'(bus.s_ready), 0);
        chk({tag, "_strobe"}, 64'(bus.frame_strobe), 0);
        chk({tag, "_synced"}, 64'(bus.synced), 0);
        chk({tag, "_error"}, 64'(bus.error), 0);
        chk({tag, "_col"}, 64'(bus.frame_col), 0);
        chk({tag, "_idx"}, 64'(bus.frame_idx), 0);
        chk({tag, "_data_zero"}, 64'(bus.frame_data == '0), 1);
    endtask

    // Monitor: every strobe is matched against the oldest expected frame
    initial begin
        forever begin
            @(negedge clk);
            if (bus.frame_strobe) begin
                chk("strobe_not_back_to_back", 64'(prev_strobe), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got strobe col=%0d idx=%0d expected none",
                             bus.frame_col, bus.frame_idx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("strobe_col", 64'(bus.frame_col), 64'(e.col));
                    chk("strobe_idx", 64'(bus.frame_idx), 64'(e.idx));
                    chk("strobe_top_word", 64'(bus.frame_data[32*FW-1 -: 32]), 64'(e.data[32*FW-1 -: 32]));
                    checks++;
                    if (bus.frame_data !== e.data) begin
                        errors++;
                        $display("FAIL strobe_data: got %0h expected %0h", bus.frame_data, e.data);
                    end
                end
            end
            prev_strobe = bus.frame_strobe;
        end
    end

    initial begin
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        resetn      = 1'b0;

        // Reset then sync
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        resetn = 1'b1;
        @(negedge clk);
        chk("s_ready_after_release", 64'(bus.s_ready), 1);
        do_sync();
        chk("synced_after_sync", 64'(bus.synced), 1);
        chk("error_after_sync", 64'(bus.error), 0);
        chk("strobe_after_sync", 64'(bus.frame_strobe), 0);

        // Desync, then misaligned sync
        send_word(32'h0000_0000, 0);
        chk("desync", 64'(bus.synced), 0);
        send_byte(8'h00); send_byte(8'hFA); send_byte(8'hFA); send_byte(8'hB0); send_byte(8'hFA);
        chk("misaligned_not_yet", 64'(bus.synced), 0);
        send_byte(8'hB1);
        chk("misaligned_synced", 64'(bus.synced), 1);

        // Two-frame write to col 3, idx 5 and 6
        send_word(32'h0103_0502, 0);
        send_frame(32'h1000_0000, 0, 1'b1, 4'd3, 5'd5);
        chk("stall1_a", 64'(bus.s_ready), 0);
        @(negedge clk);
        chk("stall1_b", 64'(bus.s_ready), 0);
        @(negedge clk);
        chk("stall1_end", 64'(bus.s_ready), 1);
        send_frame(32'h1000_0000 + 32'(FW), 0, 1'b1, 4'd3, 5'd6);
        chk("stall2_a", 64'(bus.s_ready), 0);
        @(negedge clk);
        chk("stall2_b", 64'(bus.s_ready), 0);
        @(negedge clk);
        chk("stall2_end", 64'(bus.s_ready), 1);
        chk("idx_after_hold", 64'(bus.frame_idx), 7);
        // Back in HEADER: a no-op header keeps sync and raises no error
        send_word(32'h0100_0000, 0);
        chk("noop_synced", 64'(bus.synced), 1);
        chk("noop_error", 64'(bus.error), 0);

        // Bad column
        send_word(32'h0110_0001, 0);
        chk("badcol_error", 64'(bus.error), 1);
        chk("badcol_synced", 64'(bus.synced), 0);
        repeat (4) @(negedge clk);
        do_sync();
        chk("resync_error_clear", 64'(bus.error), 0);
        chk("resync_synced", 64'(bus.synced), 1);

        // Frame range overflow: first 19 + 2 > 20
        send_word(32'h0100_1302, 0);
        chk("badrange_error", 64'(bus.error), 1);
        do_sync();

        // Last legal frame slot with backpressure gaps, then desync
        send_word(32'h010F_1301, 0);
        send_frame(32'hA5C3_0000, 3, 1'b1, 4'd15, 5'd19);
        repeat (2) @(negedge clk);
        send_word(32'h0000_0000, 0);
        chk("desync_after_frame", 64'(bus.synced), 0);

`ifdef CFG_LOADER_CSUM_EN
        // Corrupted checksum: frame rejected
        do_sync();
        corrupt_csum = 1'b1;
        send_word(32'h0101_0001, 0);
        send_frame(32'h5555_0000, 0, 1'b0, 4'd1, 5'd0);
        chk("csum_bad_error", 64'(bus.error), 1);
        chk("csum_bad_synced", 64'(bus.synced), 0);
        corrupt_csum = 1'b0;
`endif

        // Reset in the middle of a frame
        do_sync();
        send_word(32'h0102_0001, 0);
        for (int k = 0; k < 5; k++) send_word(32'hDEAD_0000 + 32'(k), 0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("midrst");
        resetn = 1'b1;
        repeat (FW + 4) @(negedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
